// File: rtl/qram_sdram_bank.sv
// qram_sdram_bank: differential-pair QRAM word array behind an SDRAM-style
// activate/access/precharge command engine with periodic, timing-only refresh.
module qram_sdram_bank #(
  parameter int DataWidth       = 8,
  parameter int AddressWidth    = 4,
  parameter int RefreshInterval = 64,
  parameter int RefreshCycles   = 4
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic                    CmdValid,
  output logic                    CmdReady,
  input  logic                    CmdWrite,
  input  logic [AddressWidth-1:0] CmdAddress,
  input  logic [DataWidth-1:0]    CmdData,
  input  logic                    InjectFault,
  output logic [DataWidth-1:0]    ReadData,
  output logic                    ReadValid,
  output logic                    ReadError,
  output logic                    Refreshing
);

  localparam int Depth         = 1 << AddressWidth;
  localparam int IntervalWidth = $clog2(RefreshInterval);
  localparam int BurstWidth    = (RefreshCycles > 1) ? $clog2(RefreshCycles) : 1;

  localparam logic [IntervalWidth-1:0] IntervalReload = IntervalWidth'(RefreshInterval - 1);
  localparam logic [IntervalWidth-1:0] IntervalOne    = IntervalWidth'(1);
  localparam logic [BurstWidth-1:0]    BurstReload    = BurstWidth'(RefreshCycles - 1);
  localparam logic [BurstWidth-1:0]    BurstOne       = BurstWidth'(1);

  typedef enum logic [2:0] {
    Idle,
    Activate,
    Access,
    Precharge,
    Refresh
  } bankState;

  bankState                 state;
  logic                     refreshPending;
  logic [IntervalWidth-1:0] intervalCount;
  logic [BurstWidth-1:0]    burstCount;

  logic                    latchedWrite;
  logic                    latchedFault;
  logic [AddressWidth-1:0] latchedAddress;
  logic [DataWidth-1:0]    latchedData;
  logic [DataWidth-1:0]    faultMask;

  logic [DataWidth-1:0] trueMem [Depth];
  logic [DataWidth-1:0] compMem [Depth];

  assign CmdReady  = (state == Idle) && !refreshPending;
  assign faultMask = DataWidth'(latchedFault);

  // Free-running refresh timer; it never pauses, so refresh cadence is independent of traffic.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      intervalCount <= IntervalReload;
    end else if (intervalCount == '0) begin
      intervalCount <= IntervalReload;
    end else begin
      intervalCount <= intervalCount - IntervalOne;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order within or across blocks.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state          <= Idle;
      refreshPending <= 1'b0;
      burstCount     <= '0;
      latchedWrite   <= 1'b0;
      latchedFault   <= 1'b0;
      latchedAddress <= '0;
      latchedData    <= '0;
      ReadData       <= '0;
      ReadValid      <= 1'b0;
      ReadError      <= 1'b0;
      Refreshing     <= 1'b0;
    end else begin
      ReadValid <= 1'b0;
      case (state)
        Idle: begin
          if (refreshPending) begin
            state          <= Refresh;
            refreshPending <= 1'b0;
            Refreshing     <= 1'b1;
            burstCount     <= BurstReload;
          end else if (CmdValid) begin
            state          <= Activate;
            latchedWrite   <= CmdWrite;
            latchedFault   <= InjectFault;
            latchedAddress <= CmdAddress;
            latchedData    <= CmdData;
          end
        end
        Activate: state <= Access;
        Access: begin
          state <= Precharge;
          if (!latchedWrite) begin
            ReadData  <= trueMem[latchedAddress];
            ReadError <= (trueMem[latchedAddress] ^ compMem[latchedAddress]) != '1;
            ReadValid <= 1'b1;
          end
        end
        Precharge: state <= Idle;
        Refresh: begin
          if (burstCount == '0) begin
            state      <= Idle;
            Refreshing <= 1'b0;
          end else begin
            burstCount <= burstCount - BurstOne;
          end
        end
        default: state <= Idle;
      endcase
      // Placed last so a new request is never lost to a same-edge clear.
      if (intervalCount == '0) refreshPending <= 1'b1;
    end
  end

  // NOTE: the arrays take the asynchronous reset on purpose (true copy all zeros,
  // complement all ones), which forces flop storage rather than a RAM macro.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < Depth; i++) begin
        trueMem[i] <= '0;
        compMem[i] <= '1;
      end
    end else if (state == Access && latchedWrite) begin
      trueMem[latchedAddress] <= latchedData;
      compMem[latchedAddress] <= ~latchedData ^ faultMask;
    end
  end

endmodule

// File: tb/tb_qram_sdram_bank.sv
// Directed self-checking bench for qram_sdram_bank: latency, differential fault
// detection, refresh arbitration, back-to-back throughput and mid-write reset.
module tb_qram_sdram_bank;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       CmdValid = 1'b0;
  logic       CmdReady;
  logic       CmdWrite = 1'b0;
  logic [3:0] CmdAddress = '0;
  logic [7:0] CmdData = '0;
  logic       InjectFault = 1'b0;
  logic [7:0] ReadData;
  logic       ReadValid;
  logic       ReadError;
  logic       Refreshing;

  int checks = 0;
  int errors = 0;
  int edgeCount;

  qram_sdram_bank #(
    .DataWidth(8),
    .AddressWidth(4),
    .RefreshInterval(64),
    .RefreshCycles(4)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .CmdValid(CmdValid),
    .CmdReady(CmdReady),
    .CmdWrite(CmdWrite),
    .CmdAddress(CmdAddress),
    .CmdData(CmdData),
    .InjectFault(InjectFault),
    .ReadData(ReadData),
    .ReadValid(ReadValid),
    .ReadError(ReadError),
    .Refreshing(Refreshing)
  );

  always #5 Clock = ~Clock;

  // Edge number since reset release: edge 1 is the first rising edge with nReset high.
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) edgeCount <= 0;
    else edgeCount <= edgeCount + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] pattern(input int i);
    logic [3:0] n;
    n = 4'(i);
    return {n, ~n};
  endfunction

  // Present a command at a falling edge and wait (bounded) for acceptance.
  task automatic acceptCmd(input logic write, input logic [3:0] addr, input logic [7:0] data,
                           input logic fault, output int acceptEdge);
    CmdWrite    = write;
    CmdAddress  = addr;
    CmdData     = data;
    InjectFault = fault;
    CmdValid    = 1'b1;
    acceptEdge  = -1;
    for (int n = 0; n < 50; n++) begin
      if (CmdReady) begin
        @(posedge Clock);
        #1;
        acceptEdge = edgeCount;
        break;
      end
      @(negedge Clock);
    end
    check("accept_in_budget", 32'(acceptEdge >= 0), 1);
  endtask

  task automatic doWrite(input logic [3:0] addr, input logic [7:0] data, input logic fault,
                         output int acceptEdge);
    acceptCmd(1'b1, addr, data, fault, acceptEdge);
    @(negedge Clock);
    CmdValid = 1'b0;
    repeat (3) @(negedge Clock);
  endtask

  task automatic doRead(input string tag, input logic [3:0] addr, input logic [7:0] expData,
                        input logic expErr, output int acceptEdge);
    acceptCmd(1'b0, addr, 8'h00, 1'b0, acceptEdge);
    @(negedge Clock);
    CmdValid = 1'b0;
    check({tag, "_valid_e0"}, ReadValid, 0);
    @(negedge Clock);
    check({tag, "_valid_e1"}, ReadValid, 0);
    @(negedge Clock);
    check({tag, "_valid_e2"}, ReadValid, 1);
    check({tag, "_data"}, ReadData, expData);
    check({tag, "_error"}, ReadError, expErr);
    @(negedge Clock);
    check({tag, "_valid_e3"}, ReadValid, 0);
  endtask

  initial begin
    int e;
    int eWrite;
    int prevEdge;
    bit sawRefresh;

    #1;
    check("rst_cmdready", CmdReady, 1);
    check("rst_readvalid", ReadValid, 0);
    check("rst_readdata", ReadData, 8'h00);
    check("rst_readerror", ReadError, 0);
    check("rst_refreshing", Refreshing, 0);
    repeat (2) @(negedge Clock);
    nReset = 1'b1;

    // Fresh array reads zero with a clean differential pair.
    doRead("t1_addr3", 4'd3, 8'h00, 1'b0, e);
    check("t1_accept_edge", e, 1);

    doWrite(4'd7, 8'hA5, 1'b0, eWrite);
    doRead("t2_addr7", 4'd7, 8'hA5, 1'b0, e);
    check("t2_accept_gap", e - eWrite, 4);

    // Complement copy 0xC2 against true 0x3C gives XOR 0xFE, flagging the fault.
    doWrite(4'd2, 8'h3C, 1'b1, e);
    doRead("t3_fault", 4'd2, 8'h3C, 1'b1, e);
    doWrite(4'd2, 8'h3C, 1'b0, e);
    doRead("t3_clean", 4'd2, 8'h3C, 1'b0, e);

    // First refresh request lands at edge 64 while idle.
    while (edgeCount < 64) @(negedge Clock);
    check("rf_pending_blocks_ready", CmdReady, 0);
    check("rf_not_yet_refreshing", Refreshing, 0);
    CmdWrite   = 1'b0;
    CmdAddress = 4'd7;
    CmdValid   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      check($sformatf("rf_refreshing_%0d", k), Refreshing, 1);
      check($sformatf("rf_ready_low_%0d", k), CmdReady, 0);
    end
    @(negedge Clock);
    check("rf_refresh_done", Refreshing, 0);
    check("rf_ready_back", CmdReady, 1);
    doRead("rf_data_intact", 4'd7, 8'hA5, 1'b0, e);
    check("rf_accept_edge", e, 70);

    // Back-to-back writes with CmdValid held high.
    CmdWrite    = 1'b1;
    InjectFault = 1'b0;
    CmdValid    = 1'b1;
    prevEdge    = -1;
    for (int i = 0; i < 16; i++) begin
      CmdAddress = 4'(i);
      CmdData    = pattern(i);
      sawRefresh = 1'b0;
      e = -1;
      for (int n = 0; n < 50; n++) begin
        if (CmdReady) begin
          @(posedge Clock);
          #1;
          e = edgeCount;
          break;
        end
        if (Refreshing) sawRefresh = 1'b1;
        @(negedge Clock);
      end
      check($sformatf("b2b_accept_%0d", i), 32'(e >= 0), 1);
      @(negedge Clock);
      if (prevEdge >= 0) begin
        if (sawRefresh) check($sformatf("b2b_gap_refresh_%0d", i), 32'(e - prevEdge > 4), 1);
        else check($sformatf("b2b_gap_%0d", i), e - prevEdge, 4);
      end
      prevEdge = e;
    end
    CmdValid = 1'b0;
    repeat (3) @(negedge Clock);
    for (int i = 0; i < 16; i++) begin
      doRead($sformatf("b2b_read_%0d", i), 4'(i), pattern(i), 1'b0, e);
    end

    // Reset one cycle into a write of 0xFF to address 1: the write must be lost.
    acceptCmd(1'b1, 4'd1, 8'hFF, 1'b0, e);
    @(posedge Clock);
    #1;
    nReset   = 1'b0;
    CmdValid = 1'b0;
    #1;
    check("mr_cmdready", CmdReady, 1);
    check("mr_readvalid", ReadValid, 0);
    check("mr_readdata", ReadData, 8'h00);
    check("mr_readerror", ReadError, 0);
    check("mr_refreshing", Refreshing, 0);
    @(negedge Clock);
    nReset = 1'b1;
    doRead("mr_addr1", 4'd1, 8'h00, 1'b0, e);
    doRead("mr_addr7_cleared", 4'd7, 8'h00, 1'b0, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
